// File: rtl/ifetch_stage_pkg.sv
// rtl/ifetch_stage_pkg.sv - shared fetch-stage constants and types
// Purpose: common instruction-memory geometry, reset PC and NOP encoding,
//          plus the per-cycle fetch action type used by ifetch_stage.
// Ports:   none (package).
package ifetch_stage_pkg;

   localparam int unsigned IMEM_SIZE     = 4096;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_ENC       = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_ADVANCE  = 2'd0,
      IF_STALL    = 2'd1,
      IF_REDIRECT = 2'd2
   } if_action_e;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load/hold/bubble controls
// Purpose: holds one fetched instruction and its PC for the decode stage.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load                capture in_* and mark valid
//   bubble              insert NOP, clear valid, keep pc/pc4
//   in_inst/pc/pc4      next instruction word and its addresses
//   inst/pc/pc4/valid   registered IF/ID contents
//   neither load nor bubble -> hold
module ifid_reg
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_ENC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_pc4,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst  <= NOP_INST;
         pc    <= 32'h0;
         pc4   <= 32'h0;
         valid <= 1'b0;
      end else if (bubble) begin
         // Bubble wins over load; pc/pc4 keep the last real instruction's values.
         inst  <= NOP_INST;
         valid <= 1'b0;
      end else if (load) begin
         inst  <= in_inst;
         pc    <= in_pc;
         pc4   <= in_pc4;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: PC, imem request, IF/ID register
// Purpose: owns the PC, presents it to a combinational instruction memory and
//          captures the returned word into IF/ID. Priority per edge is
//          redirect > stall > advance. Optional macro IFETCH_PERF_EN adds
//          perf_fetched / perf_bubbles counters.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   iaddr / idata                  imem byte address (= pc) / returned word
//   stall                          hold pc and IF/ID
//   redirect_valid / redirect_pc   taken branch/jump and its target
//   id_inst/id_pc/id_pc4/id_valid  IF/ID contents
//   fetch_misalign                 last redirect target was not word aligned
//   fetch_oob                      pc beyond instruction memory (informational)
//   perf_fetched / perf_bubbles    advance / redirect+stall cycle counts (IFETCH_PERF_EN)
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned IMEM_BYTES = IMEM_SIZE,
   parameter logic [31:0] NOP_INST   = NOP_ENC
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] iaddr,
   input  logic [31:0] idata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic        fetch_misalign,
`ifdef IFETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles,
`endif
   output logic        fetch_oob
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   if_action_e  action;

   assign pc_plus4  = pc + 32'd4;
   assign iaddr     = pc;
   // Memory aliases by truncation, so this only flags, never blocks fetch.
   assign fetch_oob = (pc >= 32'(IMEM_BYTES));

   always_comb begin
      action = IF_ADVANCE;
      if (redirect_valid)
         action = IF_REDIRECT;
      else if (stall)
         action = IF_STALL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc             <= RESET_PC;
         fetch_misalign <= 1'b0;
      end else begin
         case (action)
            IF_REDIRECT: begin
               pc             <= {redirect_pc[31:2], 2'b00};
               fetch_misalign <= |redirect_pc[1:0];
            end
            IF_ADVANCE:  pc <= pc_plus4;
            default:     ;
         endcase
      end
   end

   ifid_reg #(
      .NOP_INST (NOP_INST)
   ) u_ifid (
      .clk     (clk),
      .rst     (rst),
      .load    (action == IF_ADVANCE),
      .bubble  (action == IF_REDIRECT),
      .in_inst (idata),
      .in_pc   (pc),
      .in_pc4  (pc_plus4),
      .inst    (id_inst),
      .pc      (id_pc),
      .pc4     (id_pc4),
      .valid   (id_valid)
   );

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= 32'h0;
         perf_bubbles <= 32'h0;
      end else if (action == IF_ADVANCE) begin
         perf_fetched <= perf_fetched + 32'd1;
      end else begin
         perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch initiator: the requester end of the instruction-memory read port.
- Owns the PC and drives the word address to the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles decode-stage stalls and execute-stage redirects (branch/jump), inserting NOP bubbles on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 4096, instruction memory size in bytes (power of two); used for the out-of-range check.
- NOP_INST, 32'h0000_0000, instruction word placed in IF/ID on a bubble or reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- iaddr  out  32  byte address to instruction memory; equals pc.
- idata  in  32  instruction word, valid in the same cycle as iaddr (combinational memory).
- stall  in  1  hold PC and IF/ID (load-use hazard from decode).
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  target byte address.
- id_inst  out  32  IF/ID instruction.
- id_pc  out  32  PC of id_inst.
- id_pc4  out  32  id_pc + 4.
- id_valid  out  1  IF/ID holds a real instruction.
- fetch_misalign  out  1  last redirect target had bits[1:0] != 0.
- fetch_oob  out  1  current pc >= IMEM_BYTES.

Behaviour:
- Reset is asynchronous, active-low on rst; it applies immediately, including mid-stall or mid-redirect. Reset values:
  - pc = RESET_PC
  - id_inst = NOP_INST
  - id_pc = 0
  - id_pc4 = 0
  - id_valid = 0
  - fetch_misalign = 0
- iaddr = pc, combinationally. The instruction for pc is sampled at the end of the same cycle, so fetch latency is 1 cycle from pc to IF/ID.
- fetch_oob is combinational: (pc >= IMEM_BYTES). It is informational only; fetch proceeds regardless because memory aliases by address truncation.
- Per rising edge, priority is redirect > stall > advance:
  - Redirect (redirect_valid=1, stall ignored):
    - pc <= {redirect_pc[31:2], 2'b00}
    - id_valid <= 0, id_inst <= NOP_INST, id_pc/id_pc4 hold
    - fetch_misalign <= |redirect_pc[1:0]
  - Stall (stall=1, no redirect): pc and all IF/ID outputs hold. iaddr therefore re-presents the same address, and idata is refetched next cycle.
  - Advance:
    - pc <= pc + 4
    - id_inst <= idata
    - id_pc <= pc
    - id_pc4 <= pc + 4
    - id_valid <= 1
    - fetch_misalign holds
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000, and id_pc4 wraps the same way.
- fetch_misalign is sticky until the next redirect, which reloads it.
- The first advance after reset produces id_valid=1 with id_pc=RESET_PC at the end of cycle 1.
- Back-to-back redirects: each one overwrites pc, and id_valid stays 0 until the first advance cycle.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds two 32-bit outputs, both reset to 0 and wrapping at 2^32:
  - perf_fetched: increments on every advance cycle.
  - perf_bubbles: increments on every redirect cycle plus every stall cycle.
- Undefined: neither port nor either counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared macro header (the team's common include): IMEM_SIZE, IMEM_ADDR_WIDTH, RESET_PC default, NOP encoding.
- One sub-module, ifid_reg: the IF/ID register with load/hold/bubble controls, reused for later pipeline-register patterns.
- The PC next-state logic stays in ifetch_stage.

Test Plan:
- Reset then 4 free-running cycles, idata = 32'h1000_0000 + pc → iaddr steps 0,4,8,C; id_pc=0/id_inst=32'h1000_0000 after cycle 1; id_valid=1 from cycle 1.
- Stall held 3 cycles at pc=8 → iaddr stays 8; id_pc stays 4; id_valid stays 1; release advances pc to C.
- Redirect to 32'h0000_0100 with stall also high → pc=100; id_valid=0; id_inst=NOP next cycle; then id_pc=100.
- Redirect to 32'h0000_0203 → pc=200, fetch_misalign=1; a second redirect to 300 → fetch_misalign=0.
- Force pc 32'hFFFF_FFFC via redirect, then advance → pc=0, id_pc4=0; fetch_oob=1 at FFFF_FFFC and 0 at 0.
- Assert rst low mid-stall at pc=40 → all outputs return to their reset values immediately without a clock edge. With IFETCH_PERF_EN, both counters also reset to 0.
